// File: rtl/if_stage.sv
// if_stage: instruction fetch with a PC register, a variable-latency imem handshake, a skid buffer and redirect discard
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC_out,
    output logic        fetch_valid
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, tgt, tgt_n, buf_ir, buf_ir_n, buf_pc, buf_pc_n, ir_n, pc_out_n, rpc;
    logic fv_n, busy, pending;
    assign rpc = redirect_pc & ~32'h3;
    assign busy = state == REQ || state == DISCARD;
    assign pending = busy && !imem_ready;
    assign imem_req = busy && !rst;
    assign imem_addr = pc;
    // Next-state and next-output selection: redirect > stall > normal flow; IDLE ignores both
    always_comb begin
        state_n = state;
        pc_n = pc;
        tgt_n = tgt;
        buf_ir_n = buf_ir;
        buf_pc_n = buf_pc;
        ir_n = IR;
        pc_out_n = PC_out;
        fv_n = fetch_valid;
        if (state == IDLE) begin
            state_n = REQ;
        end else if (redirect) begin
            ir_n = '0;
            fv_n = 1'b0;
            buf_ir_n = '0;
            if (pending) begin
                tgt_n = rpc;
                state_n = DISCARD;
            end else begin
                pc_n = rpc;
                state_n = REQ;
            end
        end else if (state == HOLD) begin
            if (!stall) begin
                ir_n = buf_ir;
                pc_out_n = buf_pc;
                fv_n = 1'b1;
                state_n = REQ;
            end
        end else if (state == DISCARD) begin
            if (imem_ready) begin
                pc_n = tgt;
                state_n = REQ;
            end
            if (!stall) begin
                ir_n = '0;
                fv_n = 1'b0;
            end
        end else if (imem_ready) begin
            pc_n = pc + 32'd4;
            if (stall) begin
                buf_ir_n = imem_rdata;
                buf_pc_n = pc;
                state_n = HOLD;
            end else begin
                ir_n = imem_rdata;
                pc_out_n = pc;
                fv_n = 1'b1;
            end
        end else if (!stall) begin
            ir_n = '0;
            fv_n = 1'b0;
        end
    end
    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            tgt <= RESET_PC;
            buf_ir <= '0;
            buf_pc <= RESET_PC;
            IR <= '0;
            PC_out <= RESET_PC;
            fetch_valid <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            tgt <= tgt_n;
            buf_ir <= buf_ir_n;
            buf_pc <= buf_pc_n;
            IR <= ir_n;
            PC_out <= pc_out_n;
            fetch_valid <= fv_n;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a transaction-level fetch model
module tb_if_stage;
    localparam logic [31:0] RST_PC = 32'hFFFFFFFC;
    logic clk = 1'b0;
    logic rst, stall, redirect, imem_ready, imem_req, fetch_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, IR, PC_out;
    int n_checks = 0;
    int n_errors = 0;
    bit m_idle = 1'b1, m_skid = 1'b0, m_disc = 1'b0, m_fv = 1'b0;
    logic [31:0] m_pc = RST_PC, m_tgt = RST_PC, m_skid_pc = RST_PC, m_pcout = RST_PC;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .IR(IR), .PC_out(PC_out), .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    // Memory contents are a pure function of the word address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a ^ 32'h5A5A1234) * 32'h00010003 + 32'h1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp, input logic rdy);
        logic ereq;
        rst = r;
        stall = s;
        redirect = rd;
        redirect_pc = rp;
        imem_ready = rdy;
        #1;
        imem_rdata = rdy ? mem(imem_addr) : $urandom;
        #1;
        ereq = !r && !m_idle && !m_skid;
        check("imem_req", {31'b0, imem_req}, {31'b0, ereq});
        if (ereq) check("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        if (r) begin
            m_idle = 1; m_skid = 0; m_disc = 0; m_fv = 0;
            m_pc = RST_PC; m_pcout = RST_PC;
        end else if (m_idle) begin
            m_idle = 0;
        end else if (rd) begin
            m_fv = 0;
            if (!m_skid && !rdy) begin
                m_disc = 1; m_tgt = {rp[31:2], 2'b00};
            end else begin
                m_disc = 0; m_pc = {rp[31:2], 2'b00};
            end
            m_skid = 0;
        end else if (m_skid) begin
            if (!s) begin m_skid = 0; m_pcout = m_skid_pc; m_fv = 1; end
        end else if (m_disc) begin
            if (rdy) begin m_disc = 0; m_pc = m_tgt; end
            if (!s) m_fv = 0;
        end else if (rdy) begin
            if (s) begin m_skid = 1; m_skid_pc = m_pc; end
            else begin m_pcout = m_pc; m_fv = 1; end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_fv = 0;
        end
        #1;
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
        check("PC_out", PC_out, m_pcout);
        check("IR", IR, m_fv ? mem(m_pcout) : 32'h0);
    endtask

    initial begin
        int rmode;
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 32'h203, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h300, 0);
        step(0, 1, 1, 32'h400, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 1, 32'h600, 0);
        step(0, 0, 1, 32'h500, 0);
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            rmode = 1 + (i / 200) % 4;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0 ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom,
                 $urandom_range(0, 3) < rmode);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
